// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, reset PC, NOP word, skid
// entry payload and the opcode constants used by decode and benches.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // One fetched instruction together with its PC+4.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } skid_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction fetched while ID was stalled.
// Ports: clk, reset (async active-low), load/unload/clear controls,
//        din (entry to capture), dout (held entry), full (entry valid).
module fetch_skid
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  skid_entry_t din,
    output skid_entry_t dout,
    output logic        full
);

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues req/ready fetches to
// instruction memory, loads the IF/ID register, absorbs ID stalls with a
// one-entry skid buffer and handles flush/redirect.
// Ports: clk, reset (async active-low); imem_req/imem_addr/imem_ready/
//        imem_rdata memory handshake; stall_id, redirect_valid/redirect_pc
//        from downstream; IFID_Instruction/IFID_PC_plus4/IFID_valid to ID;
//        OpCode/Funct slices for Control; pc_out debug PC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = cpu_pkg::PC_RESET,
    parameter logic [XLEN-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             stall_id,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  IFID_Instruction,
    output logic [XLEN-1:0]  IFID_PC_plus4,
    output logic             IFID_valid,
    output logic [OP_W-1:0]  OpCode,
    output logic [OP_W-1:0]  Funct,
    output logic [XLEN-1:0]  pc_out
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;
    logic            accept;

    logic            skid_load;
    logic            skid_unload;
    logic            skid_clear;
    skid_entry_t     skid_din;
    skid_entry_t     skid_q;
    logic            skid_full;

    assign pc_plus4        = pc + XLEN'(4);
    assign redirect_target = word_align(redirect_pc);
    assign accept          = imem_req & imem_ready;
    assign imem_addr       = word_align(pc);
    assign pc_out          = pc;
    assign OpCode          = IFID_Instruction[31:26];
    assign Funct           = IFID_Instruction[5:0];

    // Skid control: capture on a stalled accept, drain when the stall lifts,
    // drop on any redirect.
    always_comb begin
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = redirect_valid;
        skid_din    = '{instr: imem_rdata, pc4: pc_plus4};
        if (!redirect_valid) begin
            skid_load   = (state == FETCH) && accept && stall_id;
            skid_unload = (state == HOLD) && !stall_id;
        end
    end

    fetch_skid u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (skid_din),
        .dout   (skid_q),
        .full   (skid_full)
    );

    // Fetch FSM with registered request and IF/ID outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= FETCH;
            pc               <= PC_RESET;
            target           <= PC_RESET;
            imem_req         <= 1'b0;
            IFID_Instruction <= NOP_WORD;
            IFID_PC_plus4    <= '0;
            IFID_valid       <= 1'b0;
        end else if (redirect_valid) begin
            IFID_Instruction <= NOP_WORD;
            IFID_valid       <= 1'b0;
            imem_req         <= 1'b1;
            case (state)
                FETCH: begin
                    // A pending unaccepted request must complete before moving.
                    if (imem_req && !imem_ready) begin
                        target <= redirect_target;
                        state  <= DRAIN;
                    end else begin
                        pc    <= redirect_target;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    pc    <= redirect_target;
                    state <= FETCH;
                end
                DRAIN: begin
                    if (accept) begin
                        pc    <= redirect_target;
                        state <= FETCH;
                    end else begin
                        target <= redirect_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (accept) begin
                        pc <= pc_plus4;
                        if (stall_id) begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            IFID_Instruction <= imem_rdata;
                            IFID_PC_plus4    <= pc_plus4;
                            IFID_valid       <= 1'b1;
                        end
                    end else if (!stall_id) begin
                        IFID_Instruction <= NOP_WORD;
                        IFID_valid       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        IFID_Instruction <= skid_q.instr;
                        IFID_PC_plus4    <= skid_q.pc4;
                        IFID_valid       <= skid_full;
                        state            <= FETCH;
                        imem_req         <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Data returned for the pre-redirect address is dropped.
                    imem_req <= 1'b1;
                    if (accept) begin
                        pc    <= target;
                        state <= FETCH;
                    end
                    if (!stall_id) begin
                        IFID_Instruction <= NOP_WORD;
                        IFID_valid       <= 1'b0;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus a scoreboard that tracks
// the expected fetch address and instruction delivery order.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC_plus4;
    logic        IFID_valid;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] pc_out;

    int n_vec;
    int n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .stall_id         (stall_id),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC_plus4    (IFID_PC_plus4),
        .IFID_valid       (IFID_valid),
        .OpCode           (OpCode),
        .Funct            (Funct),
        .pc_out           (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / protocol monitor ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    logic [31:0] tgt;
    logic        disc;
    logic        prev_ok;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic        prev_stall;
    logic        prev_redir;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc4;
    logic        prev_valid;

    always @(negedge clk) begin
        logic acc;
        exp_t e;
        if (!reset) begin
            sb.delete();
            exp_addr = RST_PC;
            tgt      = RST_PC;
            disc     = 1'b0;
            prev_ok  = 1'b0;
        end else begin
            if (prev_ok) begin
                if (prev_pend) begin
                    check32("req_held", 32'(imem_req), 32'd1);
                    check32("addr_held", imem_addr, prev_addr);
                end
                if (prev_redir) begin
                    check32("flush_valid", 32'(IFID_valid), 32'd0);
                    check32("flush_instr", IFID_Instruction, NOP);
                end else if (prev_stall) begin
                    check32("frozen_instr", IFID_Instruction, prev_instr);
                    check32("frozen_pc4", IFID_PC_plus4, prev_pc4);
                    check32("frozen_valid", 32'(IFID_valid), 32'(prev_valid));
                end else if (IFID_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_extra: got instr %08h pc4 %08h, expected none", IFID_Instruction, IFID_PC_plus4);
                    end else begin
                        e = sb.pop_front();
                        check32("sb_instr", IFID_Instruction, e.instr);
                        check32("sb_pc4", IFID_PC_plus4, e.pc4);
                        check32("sb_opcode", 32'(OpCode), 32'(e.instr[31:26]));
                        check32("sb_funct", 32'(Funct), 32'(e.instr[5:0]));
                    end
                end
            end
            acc = imem_req && imem_ready;
            if (acc) check32("fetch_addr", imem_addr, exp_addr);
            if (redirect_valid) begin
                sb.delete();
                tgt = {redirect_pc[31:2], 2'b00};
                if (acc || !imem_req) begin
                    exp_addr = tgt;
                    disc     = 1'b0;
                end else begin
                    disc = 1'b1;
                end
            end else if (acc) begin
                if (disc) begin
                    exp_addr = tgt;
                    disc     = 1'b0;
                end else begin
                    sb.push_back('{instr: mem_word(imem_addr), pc4: imem_addr + 32'd4});
                    exp_addr = exp_addr + 32'd4;
                end
            end
            prev_pend  = imem_req && !imem_ready;
            prev_addr  = imem_addr;
            prev_stall = stall_id;
            prev_redir = redirect_valid;
            prev_instr = IFID_Instruction;
            prev_pc4   = IFID_PC_plus4;
            prev_valid = IFID_valid;
            prev_ok    = 1'b1;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ready;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic stl, input logic rd,
                                input logic [31:0] rpc, input logic ereq,
                                input logic [31:0] eaddr, input logic ev,
                                input logic [31:0] epc4);
        vec_t v;
        v.ready = rdy;  v.stall = stl;  v.redir = rd;  v.rpc = rpc;
        v.exp_req = ereq;  v.exp_addr = eaddr;  v.exp_valid = ev;  v.exp_pc4 = epc4;
        return v;
    endfunction

    vec_t vecs[24];

    task automatic drive(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
        imem_ready     = rdy;
        stall_id       = stl;
        redirect_valid = rd;
        redirect_pc    = rpc;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);

        // Streaming start, stall into skid, release.
        vecs[0]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_0000, 0, 32'h0);
        vecs[1]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_0004, 1, 32'h0040_0004);
        vecs[2]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_0008, 1, 32'h0040_0008);
        vecs[3]  = mk(1, 1, 0, 32'h0,         0, 32'h0040_000C, 1, 32'h0040_0008);
        vecs[4]  = mk(1, 1, 0, 32'h0,         0, 32'h0040_000C, 1, 32'h0040_0008);
        vecs[5]  = mk(1, 1, 0, 32'h0,         0, 32'h0040_000C, 1, 32'h0040_0008);
        vecs[6]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_000C, 1, 32'h0040_000C);
        vecs[7]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0010);
        // Redirect while streaming.
        vecs[8]  = mk(1, 0, 1, 32'h0040_0100, 1, 32'h0040_0100, 0, 32'h0);
        vecs[9]  = mk(1, 0, 0, 32'h0,         1, 32'h0040_0104, 1, 32'h0040_0104);
        // Memory not ready, two redirects, drain.
        vecs[10] = mk(0, 0, 0, 32'h0,         1, 32'h0040_0104, 0, 32'h0);
        vecs[11] = mk(0, 0, 1, 32'h0040_0200, 1, 32'h0040_0104, 0, 32'h0);
        vecs[12] = mk(0, 0, 1, 32'h0040_0300, 1, 32'h0040_0104, 0, 32'h0);
        vecs[13] = mk(0, 0, 0, 32'h0,         1, 32'h0040_0104, 0, 32'h0);
        vecs[14] = mk(1, 0, 0, 32'h0,         1, 32'h0040_0300, 0, 32'h0);
        vecs[15] = mk(1, 0, 0, 32'h0,         1, 32'h0040_0304, 1, 32'h0040_0304);
        // Redirect and stall together while in HOLD.
        vecs[16] = mk(1, 1, 0, 32'h0,         0, 32'h0040_0308, 1, 32'h0040_0304);
        vecs[17] = mk(1, 1, 1, 32'h0040_0400, 1, 32'h0040_0400, 0, 32'h0);
        vecs[18] = mk(1, 0, 0, 32'h0,         1, 32'h0040_0404, 1, 32'h0040_0404);
        // Unaligned target at the top of memory, PC wraps.
        vecs[19] = mk(1, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[20] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_0000);
        vecs[21] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0004);
        // Stall with memory not ready, then redirect into DRAIN.
        vecs[22] = mk(0, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0004);
        vecs[23] = mk(0, 0, 1, 32'h0040_0500, 1, 32'h0000_0004, 0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check32("rst_req", 32'(imem_req), 32'd0);
        check32("rst_valid", 32'(IFID_valid), 32'd0);
        check32("rst_instr", IFID_Instruction, NOP);
        check32("rst_pc4", IFID_PC_plus4, 32'h0);
        check32("rst_pc", pc_out, RST_PC);
        check32("rst_addr", imem_addr, RST_PC);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].ready, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            @(posedge clk);
            #1;
            check32($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check32($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check32($sformatf("v%0d_valid", i), 32'(IFID_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check32($sformatf("v%0d_pc4", i), IFID_PC_plus4, vecs[i].exp_pc4);
            else
                check32($sformatf("v%0d_nop", i), IFID_Instruction, NOP);
        end

        // Reset pulsed mid-DRAIN takes effect without waiting for a clock.
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check32("midrst_req", 32'(imem_req), 32'd0);
        check32("midrst_valid", 32'(IFID_valid), 32'd0);
        check32("midrst_instr", IFID_Instruction, NOP);
        check32("midrst_pc", pc_out, RST_PC);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Random traffic checked by the scoreboard.
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 11) == 0,
                  RST_PC + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3)));
            @(posedge clk);
            #1;
        end

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
